// File: rtl/sample_framer.sv
// sample_framer: buffers samples in a DEPTH-entry FIFO and emits them as frames of
// frame_len samples on request. One sample per cycle, oldest first, with go on the
// first sample and finish on the last.
// Optional feature: define FRAMER_DROP_CNT_EN to build the saturating dropped-write
// counter on drop_cnt; without it drop_cnt is tied to zero.
module sample_framer #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic [3:0]       frame_len,
    output logic [WIDTH-1:0] data_out,
    output logic             go,
    output logic             finish,
    output logic             busy,
    output logic             full,
    output logic             empty,
    output logic             err,
    output logic [7:0]       drop_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [3:0]       rem_q, rem_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             go_q, go_d;
    logic             finish_q, finish_d;
    logic             err_q, err_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic pop;
    logic wr_accept;
    logic len_ok;

    // Frame FSM: decides acceptance of start, pops one entry per RUN cycle.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        data_out_d = data_out_q;
        go_d       = 1'b0;
        finish_d   = 1'b0;
        err_d      = 1'b0;
        pop        = 1'b0;
        len_ok     = (frame_len >= 4'd2) && (32'(frame_len) <= DEPTH) &&
                     (32'(count_q) >= 32'(frame_len));
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (len_ok) begin
                        state_d = StRun;
                        pop     = 1'b1;
                        go_d    = 1'b1;
                        // rem counts samples still to pop after the first one
                        rem_d   = frame_len - 4'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (rem_q != 4'd0) begin
                    pop      = 1'b1;
                    rem_d    = rem_q - 4'd1;
                    finish_d = (rem_q == 4'd1);
                end else begin
                    // current cycle presents the last sample
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (pop) begin
            data_out_d = mem_q[rd_ptr_q];
        end
    end

    // FIFO bookkeeping: a write into a full FIFO is accepted only alongside a pop.
    always_comb begin
        wr_accept = wr_en && ((32'(count_q) < DEPTH) || pop);
        count_d   = count_q + CW'(wr_accept) - CW'(pop);
        rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d  = wr_accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
        full_d    = (count_d == CW'(DEPTH));
        empty_d   = (count_d == '0);
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            rem_q      <= '0;
            data_out_q <= '0;
            go_q       <= 1'b0;
            finish_q   <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            data_out_q <= data_out_d;
            go_q       <= go_d;
            finish_q   <= finish_d;
            err_q      <= err_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
        end
    end

    // Sample storage; contents need no reset since the pointers are cleared.
    always_ff @(posedge clock) begin
        if (!reset && wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef FRAMER_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of writes refused because the FIFO was full.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (wr_en && !wr_accept && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 8'd0;
`endif

    assign data_out = data_out_q;
    assign go       = go_q;
    assign finish   = finish_q;
    assign busy     = (state_q == StRun);
    assign full     = full_q;
    assign empty    = empty_q;
    assign err      = err_q;

endmodule
